// File: rtl/input_pulse_gen_pkg.sv
// Shared types and helpers for the button front end: lockout FSM states and
// rise-vector decoding used by the top-level symbol FSM.
package input_pulse_pkg;

  typedef enum logic {S_IDLE, S_LOCK} lock_state_t;

  // Widest rise vector the helpers accept; narrower vectors are zero-extended.
  localparam int MAX_CH = 32;

  function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (v[i]) cnt = cnt + 1;
    end
    return cnt;
  endfunction

  function automatic int unsigned onehot_idx(input logic [MAX_CH-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/input_debounce_ch.sv
// One button channel: synchroniser chain, saturating debounce counter,
// debounced level and its rising-edge detect.
module input_debounce_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk_1H,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CNTW = $clog2(DB_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p1;
  logic [CNTW-1:0]        cnt;
  logic                   db_p1;
  logic                   db_p2;

  assign s_p1 = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk_1H or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      cnt     <= '0;
      db_p1   <= 1'b0;
      db_p2   <= 1'b0;
    end else begin
      // stage p0: shift raw input through the synchroniser
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn};
      // stage p1: flip the debounced level only after a full run of mismatches
      if (s_p1 == db_p1) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db_p1 <= s_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // stage p2: delayed level for edge detection
      db_p2 <= db_p1;
    end
  end

  assign level = db_p1;
  assign rise  = db_p1 & ~db_p2;

endmodule

// File: rtl/input_pulse_gen.sv
// N-channel button front end: per-channel debounce plus a lockout FSM that
// turns channel rises into single symbol events or collision strobes.
module input_pulse_gen
  import input_pulse_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int PULSE_MODE  = 1,
  localparam int IDXW       = $clog2(NUM_CH)
) (
  input  logic              clk_1H,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] ch_level,
  output logic [NUM_CH-1:0] ch_pulse,
  output logic              any_pulse,
  output logic              bit_valid,
  output logic [IDXW-1:0]   bit_value,
  output logic              collision
);

  logic [NUM_CH-1:0] rise;
  logic [MAX_CH-1:0] rise_ext;
  int unsigned       rise_cnt;
  lock_state_t       state;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_ch (
      .clk_1H(clk_1H),
      .rst_n (rst_n),
      .btn   (btn_in[i]),
      .level (ch_level[i]),
      .rise  (rise[i])
    );
  end

  if (PULSE_MODE != 0) begin : g_pulse
    logic [NUM_CH-1:0] pulse_p3;
    always_ff @(posedge clk_1H or negedge rst_n) begin
      if (!rst_n) pulse_p3 <= '0;
      else        pulse_p3 <= rise;
    end
    assign ch_pulse = pulse_p3;
  end else begin : g_level
    assign ch_pulse = ch_level;
  end

  assign any_pulse = |ch_pulse;

  assign rise_ext = MAX_CH'(rise);
  assign rise_cnt = popcount(rise_ext);

  // stage p3: lockout FSM with registered strobes
  always_ff @(posedge clk_1H or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_valid <= 1'b0;
      bit_value <= '0;
      collision <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      collision <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise_cnt == 1) begin
            bit_valid <= 1'b1;
            bit_value <= IDXW'(onehot_idx(rise_ext));
            state     <= S_LOCK;
          end else if (rise_cnt >= 2) begin
            collision <= 1'b1;
            state     <= S_LOCK;
          end
        end
        S_LOCK: begin
          // Stay locked until every channel is released; rises here are not symbols.
          if (ch_level == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
